// File: rtl/cla5_wide_add_seq_if.sv
// Request/response bundle between a client and the wide-add sequencer.
//   start      : request, sampled only while busy=0
//   a, b, cin  : W-bit operands and slice-0 carry-in, captured on accepted start
//   busy       : operation in progress
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result, held until the next done
interface cla5_wide_add_seq_if #(
   parameter int unsigned NCHUNK = 4
);
   localparam int unsigned W = 5 * NCHUNK;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/cla5_wide_add_seq.sv
// Builds a W = 5*NCHUNK bit adder by streaming 5-bit slices through an
// external registered 5-bit CLA and chaining its carry-out slice to slice.
//   clk, rst          : clock and synchronous active-high reset
//   bus (slave)       : start/a/b/cin request, busy/done/sum/cout response
//   add_a/add_b/add_cin : slice operands and carry driven to the CLA
//   add_sum/add_cout  : CLA result, valid ADD_LAT edges after an issue
module cla5_wide_add_seq #(
   parameter int unsigned NCHUNK  = 4,
   parameter int unsigned ADD_LAT = 3
) (
   input  logic                clk,
   input  logic                rst,
   cla5_wide_add_seq_if.slave  bus,
   output logic [4:0]          add_a,
   output logic [4:0]          add_b,
   output logic                add_cin,
   input  logic [4:0]          add_sum,
   input  logic                add_cout
);
   localparam int unsigned W      = 5 * NCHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned CW     = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam int unsigned LAT_M1 = ADD_LAT - 1;
   localparam int unsigned LAST   = NCHUNK - 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [IW-1:0] idx;
   logic [CW-1:0] wcnt;
   logic          busy_q;
   logic          done_q;
   logic [W-1:0]  sum_q;
   logic          cout_q;

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

   // Sequencer: accept, issue slices, sample each ADD_LAT edges after its issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         idx     <= '0;
         wcnt    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         add_a   <= '0;
         add_b   <= '0;
         add_cin <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            // DONE accepts exactly like IDLE so a held start issues back-to-back.
            IDLE, DONE: begin
               if (bus.start) begin
                  add_a   <= bus.a[4:0];
                  add_b   <= bus.b[4:0];
                  add_cin <= bus.cin;
                  // Remaining slices are kept pre-shifted so the next one is always at [4:0].
                  a_sh    <= bus.a >> 5;
                  b_sh    <= bus.b >> 5;
                  idx     <= '0;
                  wcnt    <= CW'(LAT_M1);
                  busy_q  <= 1'b1;
                  state   <= WAIT;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (wcnt != '0) begin
                  wcnt <= wcnt - 1'b1;
               end else begin
                  sum_q[5 * 32'(idx) +: 5] <= add_sum;
                  if (32'(idx) == LAST) begin
                     cout_q <= add_cout;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     // Inter-slice carry comes only from the CLA's carry-out.
                     add_a   <= a_sh[4:0];
                     add_b   <= b_sh[4:0];
                     add_cin <= add_cout;
                     a_sh    <= a_sh >> 5;
                     b_sh    <= b_sh >> 5;
                     idx     <= idx + 1'b1;
                     wcnt    <= CW'(LAT_M1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cla5_wide_add_seq.sv
// Self-checking bench for cla5_wide_add_seq with a behavioural registered CLA.
module tb_cla5_wide_add_seq;
   localparam int unsigned NCHUNK  = 4;
   localparam int unsigned ADD_LAT = 3;
   localparam int unsigned W       = 5 * NCHUNK;
   localparam int          NLAT    = NCHUNK * ADD_LAT;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] add_a, add_b, add_sum;
   logic       add_cin, add_cout;
   logic [5:0] pipe1, pipe2;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   cla5_wide_add_seq_if #(.NCHUNK(NCHUNK)) bus ();

   cla5_wide_add_seq #(.NCHUNK(NCHUNK), .ADD_LAT(ADD_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Registered 5-bit adder: result is sampled ADD_LAT (=3) edges after inputs change.
   always @(posedge clk) begin
      pipe1 <= 6'(add_a) + 6'(add_b) + 6'(add_cin);
      pipe2 <= pipe1;
   end
   assign add_sum  = pipe2[4:0];
   assign add_cout = pipe2[5];

   function automatic logic [W:0] ref_add(logic [W-1:0] x, logic [W-1:0] y, logic c);
      return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
   endfunction

   // Carry into slice i: carry out of the low 5*i bits of x + y + c.
   function automatic logic exp_carry(logic [W-1:0] x, logic [W-1:0] y, logic c, int i);
      logic [W:0] m, s;
      m = ((W+1)'(1) << (5 * i)) - (W+1)'(1);
      s = ((W+1)'(x) & m) + ((W+1)'(y) & m) + (W+1)'(c);
      return s[5 * i];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one operation and collects its observed behaviour.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output int lat,
                         output int busy_n, output logic [NCHUNK-1:0] cin_log,
                         output logic [W-1:0] a_log);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      bus.cin   = tc;
      tick();
      bus.start = 1'b0;
      lat = 0;
      busy_n = 0;
      cin_log = '0;
      a_log = '0;
      while (bus.done !== 1'b1 && lat < 200) begin
         if (lat % ADD_LAT == 0 && lat / ADD_LAT < NCHUNK) begin
            cin_log[lat / ADD_LAT] = add_cin;
            a_log[5 * (lat / ADD_LAT) +: 5] = add_a;
         end
         if (bus.busy === 1'b1) busy_n++;
         tick();
         lat++;
      end
      rs = bus.sum;
      rc = bus.cout;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      tick();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
      total++; if (bus.sum !== '0) begin bad++; $display("FAIL reset_sum got %h want 0", bus.sum); end
      total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout got %b want 0", bus.cout); end
      total++; if ({add_a, add_b, add_cin} !== 11'd0) begin bad++;
         $display("FAIL reset_add got a=%h b=%h c=%b want 0", add_a, add_b, add_cin); end
      rst = 1'b0;
      tick();
   endtask

   task automatic check_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic tc);
      logic [W-1:0] rs, al;
      logic rc;
      int lat, bn;
      logic [NCHUNK-1:0] cl;
      logic [W:0] e;
      e = ref_add(ta, tb_v, tc);
      run_op(ta, tb_v, tc, rs, rc, lat, bn, cl, al);
      total++; if (rs !== e[W-1:0]) begin bad++; $display("FAIL %s_sum got %h want %h", nm, rs, e[W-1:0]); end
      total++; if (rc !== e[W]) begin bad++; $display("FAIL %s_cout got %b want %b", nm, rc, e[W]); end
      total++; if (lat != NLAT) begin bad++; $display("FAIL %s_latency got %0d want %0d", nm, lat, NLAT); end
      total++; if (bn != NLAT) begin bad++; $display("FAIL %s_busy_cycles got %0d want %0d", nm, bn, NLAT); end
      total++; if (al !== ta) begin bad++; $display("FAIL %s_slices_a got %h want %h", nm, al, ta); end
      for (int i = 0; i < NCHUNK; i++) begin
         total++;
         if (cl[i] !== exp_carry(ta, tb_v, tc, i)) begin bad++;
            $display("FAIL %s_add_cin[%0d] got %b want %b", nm, i, cl[i], exp_carry(ta, tb_v, tc, i)); end
      end
   endtask

   task automatic test_directed();
      check_op("one_plus_one", 20'h00001, 20'h00001, 1'b0);
      check_op("ripple_all",   20'hFFFFF, 20'h00001, 1'b0);
      check_op("max_max_cin",  20'hFFFFF, 20'hFFFFF, 1'b1);
      check_op("no_carry",     20'h15A5A, 20'h0A5A5, 1'b0);
      tick();
   endtask

   task automatic test_ignore_start();
      int n;
      bus.start = 1'b1; bus.a = 20'h00003; bus.b = 20'h00004; bus.cin = 1'b0;
      tick();                              // edge S
      bus.start = 1'b0;
      tick(); tick(); tick();              // edges S+1..S+3
      bus.start = 1'b1; bus.a = 20'h11111; bus.b = 20'h11111; bus.cin = 1'b1;
      tick();                              // edge S+4
      bus.start = 1'b0;
      n = 4;
      while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
      total++; if (n != NLAT) begin bad++; $display("FAIL ignore_latency got %0d want %0d", n, NLAT); end
      total++; if (bus.sum !== 20'h00007) begin bad++; $display("FAIL ignore_sum got %h want 00007", bus.sum); end
      total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL ignore_cout got %b want 0", bus.cout); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n;
      logic [W:0] e1, e2;
      e1 = ref_add(20'h0ABCD, 20'h01234, 1'b0);
      e2 = ref_add(20'h54321, 20'h0F0F0, 1'b1);
      bus.start = 1'b1; bus.a = 20'h0ABCD; bus.b = 20'h01234; bus.cin = 1'b0;
      tick();                              // edge S
      bus.a = 20'h54321; bus.b = 20'h0F0F0; bus.cin = 1'b1;  // start stays high
      n = 0;
      while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
      total++; if (n != NLAT) begin bad++; $display("FAIL b2b_first_latency got %0d want %0d", n, NLAT); end
      total++; if ({bus.cout, bus.sum} !== e1) begin bad++;
         $display("FAIL b2b_first_result got %h want %h", {bus.cout, bus.sum}, e1); end
      tick();                              // edge S+13
      total++; if ({bus.done, bus.busy} !== 2'b01) begin bad++;
         $display("FAIL b2b_reissue got done=%b busy=%b want done=0 busy=1", bus.done, bus.busy); end
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 200) begin tick(); n++; end
      total++; if (n != NLAT) begin bad++; $display("FAIL b2b_second_latency got %0d want %0d", n, NLAT); end
      total++; if ({bus.cout, bus.sum} !== e2) begin bad++;
         $display("FAIL b2b_second_result got %h want %h", {bus.cout, bus.sum}, e2); end
      tick();
   endtask

   task automatic test_reset_mid();
      bus.start = 1'b1; bus.a = 20'h12345; bus.b = 20'h54321; bus.cin = 1'b0;
      tick();                              // edge S
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) tick();  // edges S+1..S+6
      rst = 1'b1;
      tick();                              // edge S+7
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      total++; if (bus.sum !== '0) begin bad++; $display("FAIL midrst_sum got %h want 0", bus.sum); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got %b want 0", bus.done); end
      check_op("after_rst", 20'hAAAAA, 20'h55555, 1'b1);
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic rc;
      for (int k = 0; k < 30; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         check_op("random", ra, rb, rc);
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      rst = 1'b0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cla5_wide_add_seq.md
Name: cla5_wide_add_seq

Overview:
- Multi-cycle sequencer that builds a W = 5*NCHUNK-bit adder from one registered 5-bit NAND-only CLA stage.
- It sits upstream of the CLA and feeds it one 5-bit operand slice plus carry-in at a time.
- It also sits downstream of the CLA: it collects each registered slice sum and carry-out, chains the carry into the next slice, and presents the full sum with a done pulse.

Parameters:
- NCHUNK, 4: number of 5-bit slices; W = 5*NCHUNK. Legal range ≥1.
- ADD_LAT, 3: rising edges from the edge that updates add_a/add_b/add_cin to the edge at which add_sum/add_cout are sampled. The registered CLA needs 3; 1 = purely combinational adder. Legal range ≥1.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when busy=0.
- a  in  W  operand A, captured on accepted start.
- b  in  W  operand B, captured on accepted start.
- cin  in  1  carry-in for slice 0, captured on accepted start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; sum/cout valid.
- sum  out  W  registered result; held until next done.
- cout  out  1  carry-out of top slice; held until next done.
- add_a  out  5  slice A to CLA a_in.
- add_b  out  5  slice B to CLA b_in.
- add_cin  out  1  slice carry to CLA cin.
- add_sum  in  5  CLA registered sum.
- add_cout  in  1  CLA registered cout.

Behaviour:
- Reset: at a rst edge, busy=0, done=0, sum=0, cout=0, add_a=0, add_b=0, add_cin=0, state=IDLE, and slice index and wait counter are cleared.
  - rst has priority over everything, including mid-operation; the in-flight result is discarded.
  - Stale data in the CLA pipeline is harmless because every sample occurs ADD_LAT edges after the newest issue.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - At an edge with start=1, latch a, b and cin.
  - Drive add_a=a[4:0], add_b=b[4:0], add_cin=cin.
  - Set idx=0, set the wait counter, set busy=1, go to WAIT. Call this edge S.
- WAIT:
  - add_* are held stable.
  - On the ADD_LAT-th edge after the issue edge, capture sum[5*idx+4:5*idx]=add_sum and carry=add_cout.
  - If idx<NCHUNK-1: on the same edge, issue slice idx+1 with add_cin=add_cout, increment idx, and stay in WAIT.
  - Else: cout=add_cout, busy=0, done=1, go to DONE.
- DONE:
  - done is high for exactly one cycle.
  - At the next edge done=0. If start=1 at that edge, a new operation is accepted exactly as from IDLE (back-to-back issue); otherwise go to IDLE.
- Timing:
  - Slice i is issued at edge S+i*ADD_LAT and sampled at edge S+(i+1)*ADD_LAT.
  - done rises after edge S+NCHUNK*ADD_LAT (edge S+12 for the defaults).
  - busy is high from after edge S until after edge S+NCHUNK*ADD_LAT.
- Start handling:
  - start while busy=1 is ignored; operands are not re-latched.
  - Input changes to a, b or cin during busy have no effect.
- Partial results: sum slices are written as they complete. sum is only architecturally valid while done=1 or afterwards until the next accepted start.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(W+1), exact for all inputs.
  - Carry between slices comes only from add_cout; the sequencer contains no W-bit adder.
- NCHUNK=1 degenerates to a single issue/sample, with done after edge S+ADD_LAT.

Test Plan:
- rst=1 for one edge, start=0, from arbitrary state → busy=0, done=0, sum=0x00000, cout=0, add_a=add_b=0, add_cin=0.
- a=0x00001, b=0x00001, cin=0, start pulse at edge S → done=1 exactly after edge S+12, sum=0x00002, cout=0; busy high for 12 cycles.
- a=0xFFFFF, b=0x00001, cin=0 → add_cin=1 on slices 1–3, sum=0x00000, cout=1.
- a=0xFFFFF, b=0xFFFFF, cin=1 → sum=0xFFFFF, cout=1. Separately, 0x15A5A + 0x0A5A5, cin=0 → sum=0x1FFFF, cout=0.
- Start 0x00003+0x00004, then at edge S+4 assert start with 0x11111+0x11111 → ignored; result 0x00007. Start held high through the done cycle → second operation accepted at edge S+13 with no idle cycle.
- Start 0x12345+0x54321, assert rst at edge S+7 → busy=0, sum=0. Then start 0xAAAAA+0x55555, cin=1 → sum=0x00000, cout=1 after 12 edges.
